// File: rtl/mem_access_if.sv
// Execute-to-memory request, data-memory bus and writeback record of mem_access_unit.
// slave is the unit's view; master is the view of everything around it.
interface mem_access_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic              in_mem_read_ena;
    logic              in_mem_write_ena;
    logic              in_write_reg_need;
    logic [4:0]        in_write_reg_addr;
    logic [DATA_W-1:0] in_result;
    logic [DATA_W-1:0] in_write_data;
    logic [ADDR_W-1:0] in_addr;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;
    logic              wb_valid;
    logic              wb_reg_need;
    logic [4:0]        wb_reg_addr;
    logic [DATA_W-1:0] wb_data;
    logic              stall_req;
    logic              exc_addr_err;
    logic              exc_bus_err;

    modport slave (
        input  in_valid, in_mem_read_ena, in_mem_write_ena, in_write_reg_need,
               in_write_reg_addr, in_result, in_write_data, in_addr, dmem_ack, dmem_rdata,
        output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_reg_need,
               wb_reg_addr, wb_data, stall_req, exc_addr_err, exc_bus_err
    );

    modport master (
        output in_valid, in_mem_read_ena, in_mem_write_ena, in_write_reg_need,
               in_write_reg_addr, in_result, in_write_data, in_addr, dmem_ack, dmem_rdata,
        input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_reg_need,
               wb_reg_addr, wb_data, stall_req, exc_addr_err, exc_bus_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage: word loads/stores over a single-outstanding req/ack bus, registered writeback.
//
// state | meaning
// IDLE  | ready; ALU and misaligned requests complete here with a 1-cycle writeback
// BUS   | dmem_req held until ack or timeout; upstream stalled
// RESP  | writeback of the finished bus access is on the outputs; next request may be taken
// ERR   | bus-error writeback on the outputs; next request may be taken
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_access_if.slave  bus
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP, S_ERR} state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic              req_need;
    logic [4:0]        req_reg_addr;
    logic [DATA_W-1:0] req_result;
    logic              ready_c, accept, is_mem, misaligned, ack_hit, timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // RESP/ERR always return to IDLE, so they can take a new request like IDLE does.
    always_comb begin
        next_state  = state;
        ready_c     = (state != S_BUS);
        accept      = bus.in_valid && ready_c;
        is_mem      = bus.in_mem_read_ena || bus.in_mem_write_ena;
        misaligned  = is_mem && (bus.in_addr[1:0] != 2'b00);
        ack_hit     = (state == S_BUS) && bus.dmem_ack;
        timeout_hit = (state == S_BUS) && !bus.dmem_ack && (cnt == CNT_MAX);
        case (state)
            S_BUS: begin
                if (ack_hit)          next_state = S_RESP;
                else if (timeout_hit) next_state = S_ERR;
            end
            default: next_state = (accept && is_mem && !misaligned) ? S_BUS : S_IDLE;
        endcase
    end

    assign bus.in_ready  = ready_c;
    assign bus.stall_req = !ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt              <= '0;
            req_need         <= 1'b0;
            req_reg_addr     <= '0;
            req_result       <= '0;
            bus.dmem_req     <= 1'b0;
            bus.dmem_we      <= 1'b0;
            bus.dmem_addr    <= '0;
            bus.dmem_wdata   <= '0;
            bus.wb_valid     <= 1'b0;
            bus.wb_reg_need  <= 1'b0;
            bus.wb_reg_addr  <= '0;
            bus.wb_data      <= '0;
            bus.exc_addr_err <= 1'b0;
            bus.exc_bus_err  <= 1'b0;
        end else begin
            bus.wb_valid     <= 1'b0;
            bus.exc_addr_err <= 1'b0;
            bus.exc_bus_err  <= 1'b0;
            bus.dmem_req     <= (next_state == S_BUS);
            if (state == S_BUS && !bus.dmem_ack && cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            if (accept) begin
                if (is_mem && !misaligned) begin
                    // write wins when both enables are set
                    req_need       <= bus.in_write_reg_need;
                    req_reg_addr   <= bus.in_write_reg_addr;
                    req_result     <= bus.in_result;
                    bus.dmem_we    <= bus.in_mem_write_ena;
                    bus.dmem_addr  <= {bus.in_addr[ADDR_W-1:2], 2'b00};
                    bus.dmem_wdata <= bus.in_write_data;
                    cnt            <= '0;
                end else begin
                    bus.wb_valid     <= 1'b1;
                    bus.wb_reg_need  <= bus.in_write_reg_need && !misaligned;
                    bus.wb_reg_addr  <= bus.in_write_reg_addr;
                    bus.wb_data      <= bus.in_result;
                    bus.exc_addr_err <= misaligned;
                end
            end
            if (ack_hit) begin
                bus.wb_valid    <= 1'b1;
                bus.wb_reg_need <= req_need && !bus.dmem_we;
                bus.wb_reg_addr <= req_reg_addr;
                bus.wb_data     <= bus.dmem_we ? req_result : bus.dmem_rdata;
            end
            if (timeout_hit) begin
                bus.wb_valid    <= 1'b1;
                bus.wb_reg_need <= 1'b0;
                bus.wb_reg_addr <= req_reg_addr;
                bus.wb_data     <= req_result;
                bus.exc_bus_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and random transactions against a word-memory model of mem_access_unit.
module tb_mem_access_unit;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] mem_model [logic [31:0]];

    always #5 clk = ~clk;

    mem_access_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m ();

    mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic scramble_inputs();
        m.in_mem_read_ena   = 1'($urandom);
        m.in_mem_write_ena  = 1'($urandom);
        m.in_write_reg_need = 1'($urandom);
        m.in_write_reg_addr = 5'($urandom);
        m.in_result         = $urandom;
        m.in_write_data     = $urandom;
        m.in_addr           = $urandom;
    endtask

    // One request from acceptance to writeback; dly = idle bus cycles before ack (>= TIMEOUT: never).
    task automatic do_txn(input bit rd, input bit wr, input bit need, input logic [4:0] ra,
                          input logic [31:0] res, input logic [31:0] wd, input logic [31:0] ad,
                          input int dly);
        bit          mem_op, mis, done, timed_out;
        logic [31:0] waddr, exp_data;
        int          n;
        mem_op = rd || wr;
        mis    = mem_op && (ad[1:0] != 2'b00);
        check("ready_before_accept", m.in_ready, 1);
        m.in_valid = 1'b1;  m.in_mem_read_ena = rd;  m.in_mem_write_ena = wr;
        m.in_write_reg_need = need;  m.in_write_reg_addr = ra;
        m.in_result = res;  m.in_write_data = wd;  m.in_addr = ad;
        step();
        m.in_valid = 1'b0;
        scramble_inputs();
        if (!mem_op || mis) begin
            check("imm_wb_valid", m.wb_valid, 1);
            check("imm_wb_need", m.wb_reg_need, mis ? 1'b0 : need);
            check("imm_wb_addr", m.wb_reg_addr, ra);
            if (!mis) check("imm_wb_data", m.wb_data, res);
            check("imm_addr_err", m.exc_addr_err, mis);
            check("imm_bus_err", m.exc_bus_err, 0);
            check("imm_no_req", m.dmem_req, 0);
            return;
        end
        waddr = {ad[31:2], 2'b00};
        if (!mem_model.exists(waddr)) mem_model[waddr] = $urandom;
        n = 0;
        done = 0;
        while (!done) begin
            check("bus_req", m.dmem_req, 1);
            check("bus_we", m.dmem_we, wr);
            check("bus_addr", m.dmem_addr, waddr);
            if (wr) check("bus_wdata", m.dmem_wdata, wd);
            check("bus_stall", m.stall_req, 1);
            check("bus_no_wb", m.wb_valid, 0);
            if (n == dly) begin
                m.dmem_ack   = 1'b1;
                m.dmem_rdata = wr ? $urandom : mem_model[waddr];
                done = 1;
            end else begin
                m.dmem_rdata = $urandom;
            end
            step();
            m.dmem_ack = 1'b0;
            n++;
            if (n == TIMEOUT) done = 1;
        end
        timed_out = (dly >= TIMEOUT);
        check("done_req_low", m.dmem_req, 0);
        check("done_wb_valid", m.wb_valid, 1);
        check("done_ready", m.in_ready, 1);
        check("done_stall_low", m.stall_req, 0);
        check("done_wb_addr", m.wb_reg_addr, ra);
        check("done_bus_err", m.exc_bus_err, timed_out);
        check("done_addr_err", m.exc_addr_err, 0);
        if (timed_out) begin
            check("err_wb_need", m.wb_reg_need, 0);
        end else begin
            exp_data = wr ? res : mem_model[waddr];
            check("resp_wb_need", m.wb_reg_need, need && !wr);
            check("resp_wb_data", m.wb_data, exp_data);
            if (wr) mem_model[waddr] = wd;
        end
    endtask

    initial begin
        logic [31:0] r;
        bit          rd, wr, mis;
        int          kind, dly;
        logic [31:0] ad;

        rst_n = 1'b0;
        m.in_valid = 1'b0;
        m.dmem_ack = 1'b0;
        m.dmem_rdata = '0;
        scramble_inputs();
        #12;
        check("rst_ready", m.in_ready, 1);
        check("rst_stall", m.stall_req, 0);
        check("rst_req", m.dmem_req, 0);
        check("rst_we", m.dmem_we, 0);
        check("rst_addr", m.dmem_addr, 0);
        check("rst_wb_valid", m.wb_valid, 0);
        check("rst_wb_data", m.wb_data, 0);
        check("rst_exc", {m.exc_addr_err, m.exc_bus_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ALU op, then back-to-back ALU ops one per cycle
        do_txn(0, 0, 1, 5, 32'h1234, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            r = $urandom;
            check("b2b_ready", m.in_ready, 1);
            m.in_valid = 1'b1;  m.in_mem_read_ena = 0;  m.in_mem_write_ena = 0;
            m.in_write_reg_need = 1;  m.in_write_reg_addr = 5'(i + 8);  m.in_result = r;
            step();
            check("b2b_wb_valid", m.wb_valid, 1);
            check("b2b_wb_data", m.wb_data, r);
            check("b2b_wb_addr", m.wb_reg_addr, 5'(i + 8));
            check("b2b_no_req", m.dmem_req, 0);
        end
        m.in_valid = 1'b0;
        step();
        check("idle_no_wb", m.wb_valid, 0);

        mem_model[32'h100] = 32'hDEADBEEF;
        do_txn(1, 0, 1, 7, 32'h55, 0, 32'h100, 2);
        do_txn(0, 1, 1, 9, 32'h77, 32'hCAFE, 32'h204, 0);
        do_txn(1, 0, 1, 3, 0, 0, 32'h204, 1);
        do_txn(1, 0, 1, 4, 32'h99, 0, 32'h102, 0);
        step();
        check("addr_err_pulse", m.exc_addr_err, 0);
        do_txn(1, 0, 1, 6, 32'h11, 0, 32'h300, TIMEOUT);
        step();
        check("bus_err_pulse", m.exc_bus_err, 0);
        check("after_err_ready", m.in_ready, 1);
        do_txn(1, 0, 1, 2, 0, 0, 32'h100, TIMEOUT - 1);
        do_txn(1, 1, 1, 1, 32'h42, 32'hBEEF0001, 32'h108, 1);

        // reset in the middle of a bus access
        m.in_valid = 1'b1;  m.in_mem_read_ena = 1;  m.in_mem_write_ena = 0;
        m.in_write_reg_need = 1;  m.in_write_reg_addr = 12;  m.in_addr = 32'h40;
        step();
        m.in_valid = 1'b0;
        check("pre_rst_req", m.dmem_req, 1);
        step();
        rst_n = 1'b0;
        #1;
        check("async_rst_req", m.dmem_req, 0);
        check("async_rst_ready", m.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        m.dmem_ack = 1'b1;
        step();
        m.dmem_ack = 1'b0;
        check("stray_ack_wb", m.wb_valid, 0);
        check("stray_ack_req", m.dmem_req, 0);
        check("stray_ack_err", m.exc_bus_err, 0);
        step();
        check("stray_ack_wb2", m.wb_valid, 0);
        do_txn(1, 0, 1, 12, 0, 0, 32'h40, 0);

        for (int t = 0; t < 60; t++) begin
            kind = int'($urandom_range(0, 3));
            rd = (kind == 1) || (kind == 3);
            wr = (kind == 2) || (kind == 3);
            mis = (kind != 0) && ($urandom_range(0, 4) == 0);
            ad = 32'h200 + (32'($urandom_range(0, 15)) << 2) + (mis ? 32'($urandom_range(1, 3)) : 32'd0);
            dly = ($urandom_range(0, 7) == 0) ? TIMEOUT : int'($urandom_range(0, 4));
            do_txn(rd, wr, 1'($urandom), 5'($urandom), $urandom, $urandom, ad, dly);
            if ($urandom_range(0, 3) == 0) begin
                step();
                check("gap_no_wb", m.wb_valid, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
